// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction sequencer and its decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN (adds the sticky ERR state).
package cpu_pkg;

  // Sequencer states. ERR only exists when illegal instructions trap.
  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_GET_A  = 3'd2,
    ST_GET_B  = 3'd3,
    ST_ALU    = 3'd4,
    ST_WR_IMM = 3'd5,
    ST_WR_REG = 3'd6
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    ,ST_ERR   = 3'd7
`endif
  } state_t;

  // Decoded instruction class.
  typedef enum logic [2:0] {
    CLS_ILLEGAL = 3'd0,
    CLS_MOV_IMM = 3'd1,
    CLS_MOV_REG = 3'd2,
    CLS_ADD     = 3'd3,
    CLS_CMP     = 3'd4,
    CLS_AND     = 3'd5,
    CLS_MVN     = 3'd6
  } instr_cls_t;

  // Opcode field [15:13]
  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field [12:11]
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  // Write-back mux select
  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  // ALU operation select
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_AND  = 2'b10;
  localparam logic [1:0] ALU_NOTB = 2'b11;

  // Sign-extend an 8-bit immediate to the 16-bit datapath width.
  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/cpu_controller_instr_dec.sv
// Instruction decoder: splits the IR into fields and classifies the instruction.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the IR continuously.
// Ports: ir (16) in; op, rn, rd, sh, rm, imm5, sximm8, cls out.
module instr_dec
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [1:0]  sh,
  output logic [2:0]  rm,
  output logic [4:0]  imm5,
  output logic [15:0] sximm8,
  output instr_cls_t  cls
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];
  assign imm5   = ir[4:0];
  assign sximm8 = sext8(ir[7:0]);

  always_comb begin
    cls = CLS_ILLEGAL;
    if (opcode == OPC_MOV) begin
      if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
      else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
    end else if (opcode == OPC_ALU) begin
      case (op)
        OP_ADD:  cls = CLS_ADD;
        OP_CMP:  cls = CLS_CMP;
        OP_AND:  cls = CLS_AND;
        default: cls = CLS_MVN;
      endcase
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Sequencing FSM + IR for the 16-bit register/ALU datapath; drives all datapath strobes.
// Latency: from s-sampling edge to w=1: MOV-imm 3, MOV-reg/MVN/CMP 5, ADD/AND 6, illegal 2 edges.
// Backpressure: s/load only honoured in WAIT (w=1); ignored while an instruction runs.
// Ports: clk, reset (sync, active-high), s, load, in[15:0]; w, err, readnum, writenum, write,
//        vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, shift, imm5, sximm8.
// Optional feature macro: CPU_CTRL_ILLEGAL_TRAP_EN -- illegal opcodes lock into ERR until reset.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic        err,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [4:0]  imm5,
  output logic [15:0] sximm8
);

  state_t     state;
  state_t     state_nxt;
  logic [15:0] ir;

  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  instr_cls_t cls;

  instr_dec u_dec (
    .ir     (ir),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .sh     (sh),
    .rm     (rm),
    .imm5   (imm5),
    .sximm8 (sximm8),
    .cls    (cls)
  );

  // IR captures on the same edge that samples s, so DECODE always sees the
  // freshly loaded word when load and s arrive together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_WAIT;
      ir    <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_WAIT && load) ir <= in;
    end
  end

  assign w     = (state == ST_WAIT);
  assign shift = sh;

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
  assign err = (state == ST_ERR);
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    readnum   = '0;
    writenum  = '0;
    write     = 1'b0;
    vsel      = VSEL_C;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    ALUop     = ALU_ADD;

    case (state)
      ST_WAIT: begin
        if (s) state_nxt = ST_DECODE;
      end

      ST_DECODE: begin
        case (cls)
          CLS_MOV_IMM:         state_nxt = ST_WR_IMM;
          CLS_MOV_REG,
          CLS_MVN:             state_nxt = ST_GET_B;
          CLS_ADD,
          CLS_CMP,
          CLS_AND:             state_nxt = ST_GET_A;
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
          default:             state_nxt = ST_ERR;
`else
          default:             state_nxt = ST_WAIT;
`endif
        endcase
      end

      ST_GET_A: begin
        readnum   = rn;
        loada     = 1'b1;
        state_nxt = ST_GET_B;
      end

      ST_GET_B: begin
        readnum   = rm;
        loadb     = 1'b1;
        state_nxt = ST_ALU;
      end

      ST_ALU: begin
        // MOV-reg passes B through the adder with A forced to zero via asel.
        if (cls == CLS_MOV_REG) begin
          ALUop = ALU_ADD;
          asel  = 1'b1;
        end else begin
          ALUop = op;
        end
        // CMP only updates status; nothing is written back.
        if (cls == CLS_CMP) begin
          loads     = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          loadc     = 1'b1;
          state_nxt = ST_WR_REG;
        end
      end

      ST_WR_IMM: begin
        write     = 1'b1;
        writenum  = rn;
        vsel      = VSEL_IMM;
        state_nxt = ST_WAIT;
      end

      ST_WR_REG: begin
        write     = 1'b1;
        writenum  = rd;
        vsel      = VSEL_C;
        state_nxt = ST_WAIT;
      end

`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
      ST_ERR: begin
        state_nxt = ST_ERR;
      end
`endif

      default: state_nxt = ST_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed self-checking bench for cpu_controller.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_cpu_controller;

  logic        clk;
  logic        reset;
  logic        s;
  logic        load;
  logic [15:0] in;
  logic        w;
  logic        err;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic [1:0]  vsel;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  ALUop;
  logic [1:0]  shift;
  logic [4:0]  imm5;
  logic [15:0] sximm8;

  int checks = 0;
  int errors = 0;

  // {write, loada, loadb, loadc, loads, asel, bsel}
  logic [6:0] strb;
  assign strb = {write, loada, loadb, loadc, loads, asel, bsel};

  cpu_controller dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .load     (load),
    .in       (in),
    .w        (w),
    .err      (err),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .ALUop    (ALUop),
    .shift    (shift),
    .imm5     (imm5),
    .sximm8   (sximm8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle away from it before checking/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start an instruction: load and s together in WAIT, consumed on the next edge.
  task automatic start(input logic [15:0] word);
    in   = word;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    s    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s     = 1'b0;
    load  = 1'b0;
    in    = 16'h0000;

    // Reset state
    step();
    chk("rst_w", w, 1);
    chk("rst_err", err, 0);
    chk("rst_strb", strb, 7'b0);
    chk("rst_sximm8", sximm8, 16'h0000);
    reset = 1'b0;
    step();
    chk("idle_w", w, 1);

    // MOV R0,#7
    start(16'hD007);
    chk("movi_dec_w", w, 0);
    chk("movi_dec_strb", strb, 7'b0);
    step();
    chk("movi_wr_strb", strb, 7'b1000000);
    chk("movi_wr_writenum", writenum, 0);
    chk("movi_wr_vsel", vsel, 2'b10);
    chk("movi_sximm8", sximm8, 16'h0007);
    step();
    chk("movi_done_w", w, 1);
    chk("movi_done_strb", strb, 7'b0);

    // MOV R1,#-2
    start(16'hD1FE);
    step();
    chk("movn_write", write, 1);
    chk("movn_writenum", writenum, 1);
    chk("movn_sximm8", sximm8, 16'hFFFE);
    chk("movn_imm5", imm5, 5'h1E);
    step();
    chk("movn_done_w", w, 1);

    // ADD R2,R1,R0,LSL#1
    start(16'hA148);
    chk("add_dec_w", w, 0);
    step();
    chk("add_geta_strb", strb, 7'b0100000);
    chk("add_geta_readnum", readnum, 1);
    step();
    chk("add_getb_strb", strb, 7'b0010000);
    chk("add_getb_readnum", readnum, 0);
    chk("add_getb_shift", shift, 2'b01);
    step();
    chk("add_alu_strb", strb, 7'b0001000);
    chk("add_alu_op", ALUop, 2'b00);
    step();
    chk("add_wr_strb", strb, 7'b1000000);
    chk("add_wr_writenum", writenum, 2);
    chk("add_wr_vsel", vsel, 2'b00);
    chk("add_pre_w", w, 0);
    step();
    chk("add_done_w", w, 1);

    // CMP R1,R0
    start(16'hA900);
    step();
    chk("cmp_geta_readnum", readnum, 1);
    step();
    chk("cmp_getb_loadb", loadb, 1);
    step();
    chk("cmp_alu_strb", strb, 7'b0000100);
    chk("cmp_alu_op", ALUop, 2'b01);
    step();
    chk("cmp_done_w", w, 1);
    chk("cmp_done_write", write, 0);

    // MOV R3,R5,LSR
    start(16'hC075);
    step();
    chk("movr_getb_strb", strb, 7'b0010000);
    chk("movr_getb_readnum", readnum, 5);
    chk("movr_shift", shift, 2'b10);
    step();
    chk("movr_alu_strb", strb, 7'b0001010);
    chk("movr_alu_op", ALUop, 2'b00);
    step();
    chk("movr_wr_writenum", writenum, 3);
    chk("movr_wr_write", write, 1);
    step();
    chk("movr_done_w", w, 1);

    // MVN R4,R2
    start(16'hB882);
    step();
    chk("mvn_getb_readnum", readnum, 2);
    step();
    chk("mvn_alu_strb", strb, 7'b0001000);
    chk("mvn_alu_op", ALUop, 2'b11);
    step();
    chk("mvn_wr_writenum", writenum, 4);
    step();
    chk("mvn_done_w", w, 1);

    // s held high: one WAIT cycle between back-to-back instructions
    in   = 16'hD007;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    step();
    chk("b2b_wr1", write, 1);
    step();
    chk("b2b_wait_w", w, 1);
    step();
    chk("b2b_restart_w", w, 0);
    s = 1'b0;
    step();
    chk("b2b_wr2", write, 1);
    step();
    chk("b2b_done_w", w, 1);

    // Reset during GET_B of ADD overrides everything pending
    start(16'hA148);
    step();
    step();
    chk("rstmid_getb_loadb", loadb, 1);
    reset = 1'b1;
    load  = 1'b1;
    s     = 1'b1;
    in    = 16'hFFFF;
    step();
    chk("rstmid_w", w, 1);
    chk("rstmid_strb", strb, 7'b0);
    chk("rstmid_ir", sximm8, 16'h0000);
    chk("rstmid_shift", shift, 2'b00);
    reset = 1'b0;
    load  = 1'b0;
    s     = 1'b0;
    step();
    chk("rstmid_idle_w", w, 1);

    // load outside WAIT is ignored
    start(16'hA148);
    step();
    load = 1'b1;
    in   = 16'hFFFF;
    step();
    step();
    chk("ldalu_loadc", loadc, 1);
    chk("ldalu_ir", sximm8, 16'h0048);
    step();
    load = 1'b0;
    step();
    chk("ldalu_done_w", w, 1);
    chk("ldalu_ir_after", sximm8, 16'h0048);

    // Illegal instruction
    start(16'hE000);
    chk("ill_dec_w", w, 0);
`ifdef CPU_CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      s    = i[0];
      load = i[0];
      step();
      chk("ill_err", err, 1);
      chk("ill_w", w, 0);
      chk("ill_strb", strb, 7'b0);
    end
    s     = 1'b0;
    load  = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ill_rst_err", err, 0);
    chk("ill_rst_w", w, 1);
`else
    chk("ill_dec_write", write, 0);
    step();
    chk("ill_w", w, 1);
    chk("ill_write", write, 0);
    chk("ill_err", err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
